adma_desc_fetch: RTL and testbench
==================================

Name: adma_desc_fetch

Overview:
ADMA descriptor-fetch controller that sequences the 32-bit system RAM port: it walks a descriptor table from a 64-bit base address and reads each 12-byte descriptor as three word reads. It decodes each descriptor, presents transfer descriptors to the data mover via a valid/ack handshake, follows link descriptors and stops on an end descriptor. It sits between the ADMA register block (start/base) and the RAM port, upstream of the data-transfer engine.

Parameters:
MAX_DESC, 16, descriptors decoded per run before the loop-guard error; counter width is 16.
DESC_STRIDE, 12, byte distance between consecutive descriptors.

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous active-high reset
start  input  1  begin a walk at base_addr; ignored unless in IDLE, DONE or ERROR
abort  input  1  synchronous return to IDLE from any state
base_addr  input  64  descriptor table byte address
ram_address  output  64  RAM byte address
ram_read  output  1  RAM read strobe
ram_data_out  input  32  RAM read data, valid the cycle after the strobe
desc_valid  output  1  descriptor presented
desc_ack  input  1  consumer accepts presented descriptor
desc_addr  output  64  decoded data address
desc_len  output  16  decoded length
desc_attr  output  6  decoded attribute field
busy  output  1  walk in progress
done  output  1  walk ended on an end descriptor
error  output  1  walk aborted on a fault

Behaviour:
- Reset (async, RESET=1): state=IDLE; ram_address=0, ram_read=0, desc_valid=0, desc_addr=0, desc_len=0, desc_attr=0, busy=0, done=0, error=0, ptr=0, desc_cnt=0.
- Descriptor layout (little-endian words at ptr): w0[5:0]=attr, w0[15:6] reserved, w0[31:16]=length; w1=addr[31:0]; w2=addr[63:32].
- attr bits: [0] valid, [1] end, [2] int, [5:4] act. Act 00=nop, 01=tran, 11=link, 10=reserved (treated as nop).
- States: IDLE, FETCH0, FETCH1, FETCH2, LAST, DECODE, PRESENT, DONE, ERROR.
- start in IDLE/DONE/ERROR: ptr<=base_addr, desc_cnt<=0, done<=0, error<=0, go to FETCH0.
- FETCH0: if ptr[1:0]!=0 or desc_cnt==MAX_DESC, go to ERROR. Otherwise ram_read=1 and ram_address=ptr.
- FETCH1: ram_read=1, ram_address=ptr+4; capture w0 from ram_data_out at the end of the cycle.
- FETCH2: ram_read=1, ram_address=ptr+8; capture w1.
- LAST: ram_read=0; capture w2.
- Fetch cost: 4 cycles per descriptor. ram_read is low in every other state.
- DECODE: desc_cnt+1, then branch:
  - valid=0: go to ERROR.
  - nop/reserved: if end, go to DONE; else ptr+=DESC_STRIDE and go to FETCH0.
  - tran: load desc_addr/len/attr, go to PRESENT.
  - link: the end bit is ignored. If addr[1:0]!=0, go to ERROR; else ptr<=addr and go to FETCH0.
- PRESENT: desc_valid=1 and desc_* held stable until desc_ack. On a desc_ack cycle, desc_valid drops next cycle; if end, go to DONE; else ptr+=DESC_STRIDE and go to FETCH0. desc_ack outside PRESENT is ignored.
- Address arithmetic: 64-bit modulo 2^64; wrap is not flagged.
- Flags: busy=1 in FETCH0..PRESENT. done=1 held in DONE; error=1 held in ERROR. Both are cleared by start, abort or reset.
- abort: next cycle state=IDLE, ram_read=0, desc_valid=0, busy=0, done=0, error=0. abort wins over a simultaneous start or desc_ack.
- start while busy: ignored.

Test Plan:
- Table at base 0: d0 act=01 valid, addr=40, len=5; d1 act=01 valid, addr=64, len=5, end=1. desc_ack one cycle after each valid. Expect desc_valid twice with (40,5) then (64,5), done=1, ram_read pulses exactly 6 times, addresses 0,4,8,12,16,20.
- Same d0, d1 without end, d2 at byte 24 = link to 0, MAX_DESC=8. Expect presentations 40,64,40,64,40,64 (the eighth decoded descriptor is d1, presented, acked), then error=1 on the next FETCH0, no further ram_read.
- d0 with valid=0 at base 0 -> error=1 after one fetch; desc_valid never asserted; busy=0.
- base_addr=2 -> error=1 the cycle after FETCH0 is entered, ram_read never asserted.
- Hold desc_ack=0 for 10 cycles in PRESENT -> desc_valid and desc_addr=40 stable, ram_read=0 throughout; then assert abort -> IDLE next cycle, desc_valid=0, busy=0.
- Assert RESET asynchronously mid-FETCH1 -> ram_read and busy drop immediately; after release, start re-walks from base_addr with desc_cnt=0.

Source files
------------

// File: rtl/adma_desc_fetch_if.sv
// adma_desc_fetch_if: RAM read port and descriptor hand-off bundle for the ADMA descriptor fetcher
interface adma_desc_fetch_if;
    logic [63:0] ram_address;
    logic        ram_read;
    logic [31:0] ram_data_out;
    logic        desc_valid;
    logic        desc_ack;
    logic [63:0] desc_addr;
    logic [15:0] desc_len;
    logic [5:0]  desc_attr;
    modport master (
        output ram_address, ram_read, desc_valid, desc_addr, desc_len, desc_attr,
        input  ram_data_out, desc_ack
    );
    modport slave (
        input  ram_address, ram_read, desc_valid, desc_addr, desc_len, desc_attr,
        output ram_data_out, desc_ack
    );
endinterface

// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: walks an ADMA descriptor table over a 32-bit RAM port and hands transfer descriptors downstream
module adma_desc_fetch #(
    parameter int MAX_DESC    = 16,
    parameter int DESC_STRIDE = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [63:0]       base_addr,
    adma_desc_fetch_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [3:0] {IDLE, FETCH0, FETCH1, FETCH2, LAST, DECODE, PRESENT, DONE, ERROR} state_t;
    state_t      state, state_n;
    logic [63:0] ptr, ptr_n, d_addr, link_addr;
    logic [15:0] cnt, cnt_n, c_len, d_len;
    logic [5:0]  c_attr, d_attr;
    logic [31:0] w1, w2;
    logic        load;
    assign link_addr      = {w2, w1};
    assign busy           = state inside {FETCH0, FETCH1, FETCH2, LAST, DECODE, PRESENT};
    assign done           = state == DONE;
    assign error          = state == ERROR;
    assign bus.desc_valid = state == PRESENT;
    assign bus.desc_addr  = d_addr;
    assign bus.desc_len   = d_len;
    assign bus.desc_attr  = d_attr;
    always_comb begin
        state_n         = state;
        ptr_n           = ptr;
        cnt_n           = cnt;
        load            = 1'b0;
        bus.ram_read    = 1'b0;
        bus.ram_address = ptr;
        case (state)
            IDLE, DONE, ERROR: if (start) begin
                state_n = FETCH0;
                ptr_n   = base_addr;
                cnt_n   = '0;
            end
            FETCH0: if (ptr[1:0] != 2'b00 || cnt == 16'(MAX_DESC)) state_n = ERROR;
                    else begin
                        bus.ram_read = 1'b1;
                        state_n      = FETCH1;
                    end
            FETCH1: begin
                bus.ram_read    = 1'b1;
                bus.ram_address = ptr + 64'd4;
                state_n         = FETCH2;
            end
            FETCH2: begin
                bus.ram_read    = 1'b1;
                bus.ram_address = ptr + 64'd8;
                state_n         = LAST;
            end
            LAST: state_n = DECODE;
            DECODE: begin
                cnt_n = cnt + 16'd1;
                if (!c_attr[0]) state_n = ERROR;
                else if (c_attr[5:4] == 2'b01) begin
                    load    = 1'b1;
                    state_n = PRESENT;
                end else if (c_attr[5:4] == 2'b11) begin
                    // link ignores its end bit; a misaligned target is a fault
                    state_n = link_addr[1:0] != 2'b00 ? ERROR : FETCH0;
                    ptr_n   = link_addr;
                end else begin
                    state_n = c_attr[1] ? DONE : FETCH0;
                    ptr_n   = ptr + 64'(DESC_STRIDE);
                end
            end
            PRESENT: if (bus.desc_ack) begin
                state_n = d_attr[1] ? DONE : FETCH0;
                ptr_n   = ptr + 64'(DESC_STRIDE);
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            load    = 1'b0;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            c_attr <= '0;
            c_len  <= '0;
            w1     <= '0;
            w2     <= '0;
            d_addr <= '0;
            d_len  <= '0;
            d_attr <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            if (state == FETCH1) begin
                c_attr <= bus.ram_data_out[5:0];
                c_len  <= bus.ram_data_out[31:16];
            end
            if (state == FETCH2) w1 <= bus.ram_data_out;
            if (state == LAST) w2 <= bus.ram_data_out;
            if (load) begin
                d_addr <= link_addr;
                d_len  <= c_len;
                d_attr <= c_attr;
            end
        end
    end
endmodule

// File: tb/tb_adma_desc_fetch.sv
// tb_adma_desc_fetch: scenario tasks against a word RAM model, expected presentations queued and popped on output
module tb_adma_desc_fetch;
    logic        CLK = 1'b0, RESET = 1'b1, start = 1'b0, abort = 1'b0;
    logic [63:0] base_addr = '0;
    logic        busy, done, error;
    adma_desc_fetch_if bus();
    adma_desc_fetch #(.MAX_DESC(8), .DESC_STRIDE(12)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .base_addr(base_addr),
        .bus(bus), .busy(busy), .done(done), .error(error)
    );
    always #5 CLK = ~CLK;

    logic [31:0] mem [0:63];
    always @(posedge CLK) if (bus.ram_read === 1'b1) bus.ram_data_out <= mem[bus.ram_address[7:2]];

    int          errors = 0, checks = 0, rd_cnt = 0;
    logic [63:0] rd_log[$];
    logic [79:0] obs[$];
    logic [79:0] exp_q[$];
    logic        prev_v = 1'b0;
    always @(negedge CLK) begin
        if (bus.ram_read === 1'b1) begin
            rd_cnt++;
            rd_log.push_back(bus.ram_address);
        end
        if (bus.desc_valid === 1'b1 && !prev_v) obs.push_back({bus.desc_addr, bus.desc_len});
        prev_v = (bus.desc_valid === 1'b1);
    end

    task automatic step;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle;
        abort = 1'b1;
        step;
        abort = 1'b0;
        step;
    endtask

    task automatic put_desc(input int ba, input logic [5:0] a, input logic [15:0] l, input logic [63:0] ad);
        mem[ba/4]     = {l, 10'd0, a};
        mem[ba/4 + 1] = ad[31:0];
        mem[ba/4 + 2] = ad[63:32];
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic kick(input logic [63:0] b);
        base_addr = b;
        start     = 1'b1;
        step;
        start     = 1'b0;
    endtask

    task automatic service(input int max, output bit to);
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < max) begin
            if (bus.desc_valid === 1'b1) begin
                step;
                bus.desc_ack = 1'b1;
                step;
                bus.desc_ack = 1'b0;
                n += 2;
            end else begin
                step;
                n++;
            end
        end
        to = !(done === 1'b1 || error === 1'b1);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        step;
        checks += 9;
        if (bus.ram_read !== 1'b0)     begin errors++; $display("FAIL reset_ram_read got %b want 0", bus.ram_read); end
        if (bus.ram_address !== 64'd0) begin errors++; $display("FAIL reset_ram_address got %0h want 0", bus.ram_address); end
        if (bus.desc_valid !== 1'b0)   begin errors++; $display("FAIL reset_desc_valid got %b want 0", bus.desc_valid); end
        if (bus.desc_addr !== 64'd0)   begin errors++; $display("FAIL reset_desc_addr got %0h want 0", bus.desc_addr); end
        if (bus.desc_len !== 16'd0)    begin errors++; $display("FAIL reset_desc_len got %0h want 0", bus.desc_len); end
        if (bus.desc_attr !== 6'd0)    begin errors++; $display("FAIL reset_desc_attr got %0h want 0", bus.desc_attr); end
        if (busy !== 1'b0)             begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)             begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (error !== 1'b0)            begin errors++; $display("FAIL reset_error got %b want 0", error); end
        RESET = 1'b0;
        step;
    endtask

    task automatic test_two_desc;
        bit to;
        int ob, lb, r0;
        logic [79:0] e;
        idle;
        clear_mem;
        put_desc(0, 6'h11, 16'd5, 64'd40);
        put_desc(12, 6'h13, 16'd5, 64'd64);
        exp_q.push_back({64'd40, 16'd5});
        exp_q.push_back({64'd64, 16'd5});
        ob = obs.size(); lb = rd_log.size(); r0 = rd_cnt;
        kick(64'd0);
        service(200, to);
        checks += 3;
        if (to)           begin errors++; $display("FAIL two_timeout got done=%b error=%b want done=1", done, error); end
        if (done !== 1'b1) begin errors++; $display("FAIL two_done got %b want 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL two_busy got %b want 0", busy); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (ob + i >= obs.size()) begin errors++; $display("FAIL two_present%0d got none want %0h", i, e); end
            else if (obs[ob + i] !== e) begin errors++; $display("FAIL two_present%0d got %0h want %0h", i, obs[ob + i], e); end
        end
        checks += 2;
        if (obs.size() - ob != 2) begin errors++; $display("FAIL two_present_count got %0d want 2", obs.size() - ob); end
        if (rd_cnt - r0 != 6)     begin errors++; $display("FAIL two_read_count got %0d want 6", rd_cnt - r0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (lb + i >= rd_log.size()) begin errors++; $display("FAIL two_addr%0d got none want %0d", i, 4 * i); end
            else if (rd_log[lb + i] !== 64'(4 * i)) begin errors++; $display("FAIL two_addr%0d got %0d want %0d", i, rd_log[lb + i], 4 * i); end
        end
    endtask

    task automatic test_loop_guard;
        bit to;
        int ob, r0, r1;
        logic [79:0] e;
        idle;
        clear_mem;
        put_desc(0, 6'h11, 16'd5, 64'd40);
        put_desc(12, 6'h11, 16'd5, 64'd64);
        put_desc(24, 6'h31, 16'd0, 64'd0);
        repeat (3) begin
            exp_q.push_back({64'd40, 16'd5});
            exp_q.push_back({64'd64, 16'd5});
        end
        ob = obs.size(); r0 = rd_cnt;
        kick(64'd0);
        service(800, to);
        checks += 4;
        if (to)             begin errors++; $display("FAIL loop_timeout got done=%b error=%b want error=1", done, error); end
        if (error !== 1'b1) begin errors++; $display("FAIL loop_error got %b want 1", error); end
        if (done !== 1'b0)  begin errors++; $display("FAIL loop_done got %b want 0", done); end
        if (rd_cnt - r0 != 24) begin errors++; $display("FAIL loop_read_count got %0d want 24", rd_cnt - r0); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (ob + i >= obs.size()) begin errors++; $display("FAIL loop_present%0d got none want %0h", i, e); end
            else if (obs[ob + i] !== e) begin errors++; $display("FAIL loop_present%0d got %0h want %0h", i, obs[ob + i], e); end
        end
        checks++;
        if (obs.size() - ob != 6) begin errors++; $display("FAIL loop_present_count got %0d want 6", obs.size() - ob); end
        r1 = rd_cnt;
        repeat (5) step;
        checks += 2;
        if (rd_cnt != r1)   begin errors++; $display("FAIL loop_no_more_reads got %0d want 0", rd_cnt - r1); end
        if (error !== 1'b1) begin errors++; $display("FAIL loop_error_held got %b want 1", error); end
    endtask

    task automatic test_invalid;
        bit to;
        int ob, r0;
        idle;
        clear_mem;
        put_desc(0, 6'h10, 16'd5, 64'd40);
        ob = obs.size(); r0 = rd_cnt;
        kick(64'd0);
        service(100, to);
        checks += 4;
        if (error !== 1'b1)    begin errors++; $display("FAIL invalid_error got %b want 1", error); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL invalid_busy got %b want 0", busy); end
        if (obs.size() != ob)  begin errors++; $display("FAIL invalid_presented got %0d want 0", obs.size() - ob); end
        if (rd_cnt - r0 != 3)  begin errors++; $display("FAIL invalid_read_count got %0d want 3", rd_cnt - r0); end
    endtask

    task automatic test_misaligned;
        int r0;
        idle;
        r0 = rd_cnt;
        kick(64'd2);
        checks += 3;
        if (bus.ram_read !== 1'b0) begin errors++; $display("FAIL mis_fetch0_read got %b want 0", bus.ram_read); end
        if (busy !== 1'b1)         begin errors++; $display("FAIL mis_fetch0_busy got %b want 1", busy); end
        if (error !== 1'b0)        begin errors++; $display("FAIL mis_fetch0_error got %b want 0", error); end
        step;
        checks += 3;
        if (error !== 1'b1)  begin errors++; $display("FAIL mis_error got %b want 1", error); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL mis_busy got %b want 0", busy); end
        if (rd_cnt != r0)    begin errors++; $display("FAIL mis_read_count got %0d want 0", rd_cnt - r0); end
    endtask

    task automatic test_hold_abort;
        int n = 0;
        idle;
        clear_mem;
        put_desc(0, 6'h11, 16'd5, 64'd40);
        put_desc(96, 6'h13, 16'd7, 64'd200);
        kick(64'd0);
        while (bus.desc_valid !== 1'b1 && n < 20) begin step; n++; end
        checks++;
        if (bus.desc_valid !== 1'b1) begin errors++; $display("FAIL hold_wait got desc_valid=%b want 1", bus.desc_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.desc_valid !== 1'b1 || bus.desc_addr !== 64'd40 || bus.ram_read !== 1'b0)
                begin errors++; $display("FAIL hold_cycle%0d got valid=%b addr=%0d rd=%b want 1/40/0", i, bus.desc_valid, bus.desc_addr, bus.ram_read); end
            start     = (i == 3);
            base_addr = 64'd96;
            step;
        end
        start        = 1'b0;
        abort        = 1'b1;
        bus.desc_ack = 1'b1;
        step;
        abort        = 1'b0;
        bus.desc_ack = 1'b0;
        checks += 4;
        if (bus.desc_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.desc_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0)           begin errors++; $display("FAIL abort_done got %b want 0", done); end
        if (error !== 1'b0)          begin errors++; $display("FAIL abort_error got %b want 0", error); end
        step;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset;
        bit to;
        int ob, lb, r0;
        logic [79:0] e;
        idle;
        clear_mem;
        put_desc(0, 6'h11, 16'd5, 64'd40);
        put_desc(12, 6'h13, 16'd5, 64'd64);
        put_desc(96, 6'h11, 16'd9, 64'd128);
        put_desc(108, 6'h13, 16'd3, 64'd160);
        kick(64'd0);
        step;
        checks++;
        if (bus.ram_read !== 1'b1) begin errors++; $display("FAIL areset_pre_read got %b want 1", bus.ram_read); end
        #2 RESET = 1'b1;
        #1;
        checks += 3;
        if (bus.ram_read !== 1'b0)     begin errors++; $display("FAIL areset_read got %b want 0", bus.ram_read); end
        if (busy !== 1'b0)             begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        if (bus.ram_address !== 64'd0) begin errors++; $display("FAIL areset_addr got %0h want 0", bus.ram_address); end
        step;
        RESET = 1'b0;
        step;
        exp_q.push_back({64'd128, 16'd9});
        exp_q.push_back({64'd160, 16'd3});
        ob = obs.size(); lb = rd_log.size(); r0 = rd_cnt;
        kick(64'd96);
        service(200, to);
        checks += 4;
        if (done !== 1'b1)     begin errors++; $display("FAIL rewalk_done got %b want 1", done); end
        if (rd_cnt - r0 != 6)  begin errors++; $display("FAIL rewalk_read_count got %0d want 6", rd_cnt - r0); end
        if (lb >= rd_log.size() || rd_log[lb] !== 64'd96)
            begin errors++; $display("FAIL rewalk_first_addr got %0d want 96", lb < rd_log.size() ? rd_log[lb] : 64'hx); end
        if (obs.size() - ob != 2) begin errors++; $display("FAIL rewalk_present_count got %0d want 2", obs.size() - ob); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (ob + i >= obs.size()) begin errors++; $display("FAIL rewalk_present%0d got none want %0h", i, e); end
            else if (obs[ob + i] !== e) begin errors++; $display("FAIL rewalk_present%0d got %0h want %0h", i, obs[ob + i], e); end
        end
    endtask

    initial begin
        bus.desc_ack = 1'b0;
        clear_mem;
        test_reset;
        test_two_desc;
        test_loop_guard;
        test_invalid;
        test_misaligned;
        test_hold_abort;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
